instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Multicycle fetch stage directly upstream of the instruction decoder.
- Holds the architectural PC and issues one word request per fetch over a request/response instruction-memory port.
- Latches the returned word into an instruction register and pulses decode_en for one cycle so the decoder can evaluate the held instr.
- Accepts PC redirects from the execute/writeback controller, including redirects that arrive mid-fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, WAIT-state cycles allowed before fetch_err; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  controller request to fetch the instruction at pc; sampled only in IDLE.
- pc_wr  input  1  PC redirect strobe (branch, jump, jalr target).
- pc_wdata  input  32  redirect target.
- pc_inc  input  1  advance pc by 4 (sequential completion); sampled only in IDLE.
- imem_req  output  1  memory request, held high in REQ.
- imem_addr  output  32  word address of the request.
- imem_gnt  input  1  memory accepted the request.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr  output  32  instruction register, feeds the decoder.
- instr_pc  output  32  PC of the word held in instr.
- pc  output  32  current architectural PC.
- decode_en  output  1  one-cycle pulse; instr is valid.
- busy  output  1  high in every state except IDLE.
- fetch_err  output  1  sticky error flag; cleared by the next accepted fetch_en.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC.
  - instr=32'h0000_0013 (NOP).
  - instr_pc=RESET_PC.
  - imem_req=0, decode_en=0, fetch_err=0, busy=0.
  - State=IDLE, redirect-pending flag cleared, timeout counter=0.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - pc_wr has priority and sets pc<=pc_wdata.
  - Otherwise pc_inc sets pc<=pc+4, wrapping modulo 2^32.
  - fetch_en moves the FSM to REQ and clears fetch_err. This is legal in the same cycle as pc_wr or pc_inc; REQ then uses the updated pc.
- REQ:
  - imem_req=1 and imem_addr=pc, held stable until imem_gnt.
  - On imem_gnt, go to WAIT and clear the counter.
  - If imem_gnt and imem_rvalid arrive in the same cycle, capture the data and go directly to DONE.
- WAIT:
  - imem_req=0; the counter increments every cycle.
  - On imem_rvalid: instr<=imem_rdata, instr_pc<=address issued, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rvalid, go to ERR. instr is left unchanged.
- DONE:
  - decode_en=1 for exactly one cycle, then return to IDLE.
  - Minimum latency from fetch_en to decode_en is 2 cycles (same-cycle gnt and rvalid), otherwise 3 cycles or more.
- ERR:
  - Set fetch_err=1, no decode_en pulse, return to IDLE next cycle.
- Redirect while busy (pc_wr outside IDLE):
  - Latch pc_wdata into the pending register; the in-flight fetch completes normally.
  - The pending value is written to pc on entry to IDLE, taking priority over pc_inc.
  - A second pc_wr before IDLE overwrites the pending value.
- pc_inc and fetch_en outside IDLE are ignored.
- Reset asserted mid-fetch aborts immediately. A late imem_rvalid arriving after reset is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: fetch_en in IDLE with pc[1:0]!=0 goes to ERR without asserting imem_req; fetch_err=1 and no decode_en pulse.
- Undefined: no check is made; imem_addr={pc[31:2],2'b00} and the fetch proceeds normally.

Test Plan:
- Reset with RESET_PC=32'h100, fetch_en; memory gnt at cycle 1, rvalid at cycle 2 with 32'h00500093 -> imem_addr=32'h100; instr=32'h00500093, instr_pc=32'h100, decode_en high exactly one cycle; pc stays 32'h100 until pc_inc, then 32'h104.
- Same-cycle gnt and rvalid -> decode_en 2 cycles after fetch_en.
- pc_wr=1 with pc_wdata=32'h200 during WAIT -> instr_pc keeps the old address; pc=32'h200 on the IDLE entry cycle; the next fetch uses imem_addr=32'h200.
- No rvalid with TIMEOUT_CYCLES=4 -> ERR after 4 WAIT cycles; fetch_err=1, no decode_en; the next fetch_en clears fetch_err.
- pc=32'hFFFF_FFFC, pc_inc -> pc=32'h0000_0000.
- FETCH_ALIGN_CHECK_EN defined, pc_wr to 32'h102, fetch_en -> imem_req stays 0 and fetch_err=1; with the macro undefined -> imem_addr=32'h100.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle instruction fetch stage with redirect handling
// Optional FETCH_ALIGN_CHECK_EN: misaligned pc on fetch_en raises fetch_err without a memory request.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_wr,
  input  logic [31:0] pc_wdata,
  input  logic        pc_inc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        decode_en,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        pend_vld;
  logic [31:0] pend_pc;
  logic [31:0] idle_pc;
  logic [31:0] ret_pc;

  // pc seen by a fetch launched this cycle: redirect beats increment
  always_comb begin
    idle_pc = pc;
    if (pc_wr)
      idle_pc = pc_wdata;
    else if (pc_inc)
      idle_pc = pc + 32'd4;
  end

  // pc applied on the edge that returns to IDLE; a redirect in the last busy cycle still counts
  always_comb begin
    ret_pc = pc;
    if (pc_wr)
      ret_pc = pc_wdata;
    else if (pend_vld)
      ret_pc = pend_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= NOP;
      instr_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      decode_en <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
      tmo_cnt   <= 8'd0;
      pend_vld  <= 1'b0;
      pend_pc   <= 32'd0;
    end else begin
      decode_en <= 1'b0;
      case (state)
        IDLE: begin
          pc <= idle_pc;
          if (fetch_en) begin
            fetch_err <= 1'b0;
            busy      <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (idle_pc[1:0] != 2'b00) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end else
`endif
            begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= {idle_pc[31:2], 2'b00};
            end
          end
        end
        REQ: begin
          if (pc_wr) begin
            pend_vld <= 1'b1;
            pend_pc  <= pc_wdata;
          end
          if (imem_gnt) begin
            imem_req <= 1'b0;
            tmo_cnt  <= 8'd0;
            if (imem_rvalid) begin
              instr     <= imem_rdata;
              instr_pc  <= imem_addr;
              decode_en <= 1'b1;
              state     <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (pc_wr) begin
            pend_vld <= 1'b1;
            pend_pc  <= pc_wdata;
          end
          if (imem_rvalid) begin
            instr     <= imem_rdata;
            instr_pc  <= imem_addr;
            decode_en <= 1'b1;
            state     <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE, ERR: begin
          pc       <= ret_pc;
          pend_vld <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        pc_wr = 1'b0;
  logic [31:0] pc_wdata = 32'd0;
  logic        pc_inc = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        decode_en;
  logic        busy;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h100), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_wr(pc_wr),
    .pc_wdata(pc_wdata), .pc_inc(pc_inc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc), .pc(pc),
    .decode_en(decode_en), .busy(busy), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_pc", pc, 32'h100);
    check("rst_instr", instr, 32'h13);
    check("rst_instr_pc", instr_pc, 32'h100);
    check("rst_req", imem_req, 0);
    check("rst_dec", decode_en, 0);
    check("rst_err", fetch_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // basic fetch: gnt one cycle, rvalid the next
    fetch_en = 1; step(); fetch_en = 0;
    check("f1_req", imem_req, 1);
    check("f1_addr", imem_addr, 32'h100);
    check("f1_busy", busy, 1);
    imem_gnt = 1; step(); imem_gnt = 0;
    check("f1_wait_req", imem_req, 0);
    check("f1_wait_dec", decode_en, 0);
    imem_rvalid = 1; imem_rdata = 32'h00500093; step(); imem_rvalid = 0;
    check("f1_dec", decode_en, 1);
    check("f1_instr", instr, 32'h00500093);
    check("f1_instr_pc", instr_pc, 32'h100);
    step();
    check("f1_dec_off", decode_en, 0);
    check("f1_idle_busy", busy, 0);
    check("f1_pc_hold", pc, 32'h100);
    pc_inc = 1; step(); pc_inc = 0;
    check("f1_pc_inc", pc, 32'h104);

    // same-cycle gnt and rvalid
    fetch_en = 1; step(); fetch_en = 0;
    check("f2_no_dec_yet", decode_en, 0);
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
    imem_gnt = 0; imem_rvalid = 0;
    check("f2_dec", decode_en, 1);
    check("f2_instr", instr, 32'hDEAD_BEEF);
    check("f2_instr_pc", instr_pc, 32'h104);
    step();
    check("f2_dec_off", decode_en, 0);

    // redirect during WAIT, pc_inc while busy ignored
    fetch_en = 1; step(); fetch_en = 0;
    imem_gnt = 1; step(); imem_gnt = 0;
    pc_wr = 1; pc_wdata = 32'h200; pc_inc = 1; step(); pc_wr = 0; pc_inc = 0;
    check("rd_pc_busy", pc, 32'h104);
    imem_rvalid = 1; imem_rdata = 32'h1234_5678; step(); imem_rvalid = 0;
    check("rd_instr_pc", instr_pc, 32'h104);
    check("rd_dec", decode_en, 1);
    step();
    check("rd_pc_idle", pc, 32'h200);
    fetch_en = 1; step(); fetch_en = 0;
    check("rd_addr", imem_addr, 32'h200);

    // timeout with TIMEOUT_CYCLES=4: four WAIT cycles then ERR
    imem_gnt = 1; step(); imem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_busy", busy, 1);
      check("to_err_early", fetch_err, 0);
      check("to_dec", decode_en, 0);
    end
    step();
    check("to_err", fetch_err, 1);
    check("to_err_dec", decode_en, 0);
    step();
    check("to_idle", busy, 0);
    check("to_sticky", fetch_err, 1);
    check("to_instr_keep", instr, 32'h1234_5678);
    fetch_en = 1; step(); fetch_en = 0;
    check("to_clear", fetch_err, 0);
    imem_gnt = 1; imem_rvalid = 1; step(); imem_gnt = 0; imem_rvalid = 0;
    step();

    // pc wrap
    pc_wr = 1; pc_wdata = 32'hFFFF_FFFC; step(); pc_wr = 0;
    check("wrap_set", pc, 32'hFFFF_FFFC);
    pc_inc = 1; step(); pc_inc = 0;
    check("wrap_pc", pc, 32'h0);

    // misaligned redirect with fetch
    pc_wr = 1; pc_wdata = 32'h102; fetch_en = 1; step(); pc_wr = 0; fetch_en = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("al_req", imem_req, 0);
    check("al_err", fetch_err, 1);
    step();
    check("al_idle_req", imem_req, 0);
    check("al_idle_err", fetch_err, 1);
    check("al_dec", decode_en, 0);
`else
    check("al_req", imem_req, 1);
    check("al_addr", imem_addr, 32'h100);
    imem_gnt = 1; imem_rvalid = 1; step(); imem_gnt = 0; imem_rvalid = 0;
    check("al_dec", decode_en, 1);
    step();
`endif

    // reset mid-fetch, then late rvalid ignored
    fetch_en = 1; step(); fetch_en = 0;
    imem_gnt = 1; step(); imem_gnt = 0;
    rst_n = 0; #1;
    check("mr_busy", busy, 0);
    check("mr_pc", pc, 32'h100);
    step();
    rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'hFFFF_0000; step(); imem_rvalid = 0;
    check("mr_late_dec", decode_en, 0);
    check("mr_late_instr", instr, 32'h13);
    check("mr_late_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
